inv_shift_rows_stream: RTL and testbench
========================================

INV_SHIFT_ROWS_STREAM -- requirements
Module: inv_shift_rows_stream

Interface
REQ-001 Parameters: none; block size fixed at 16 bytes, buffer depth fixed at 2 blocks.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous flush; discards all partial and full blocks.
REQ-005 in_valid  input  1  in_data holds a valid state byte.
REQ-006 in_ready  output  1  block accepts a byte this cycle.
REQ-007 in_data  input  8  state byte; the k-th accepted byte of a block is source byte k (0..15).
REQ-008 out_valid  output  1  out_data holds a complete InvShiftRows-transformed block.
REQ-009 out_ready  input  1  consumer takes out_data this cycle.
REQ-010 out_data  output  128  result block; byte j occupies bits [8j+7:8j].

Function
REQ-011 Byte index j = 4r+c: row r = j/4, column c = j%4.
REQ-012 Transform: out[4r+c] = in[4r+((c-r) mod 4)]; row 0 is unchanged, row r is rotated right by r.
REQ-013 Each accepted byte with source index 4r+c is written directly to destination slot 4r+((c+r) mod 4) of the current write buffer; no separate permutation stage.
REQ-014 An input handshake occurs when in_valid=1 and in_ready=1; an output handshake occurs when out_valid=1 and out_ready=1.
REQ-015 The block has two 128-bit buffers, each in state EMPTY, FILLING or FULL, plus a write select wsel, a read select rsel, and a 4-bit byte counter.
REQ-016 Buffer transitions: EMPTY->FILLING on the first byte; FILLING->FULL on the byte with counter=15; FULL->EMPTY on an output handshake.
REQ-017 The byte counter increments on each input handshake and wraps 15->0; wsel toggles on that wrap.
REQ-018 in_ready = 1 iff buffer[wsel] is not FULL; it is a registered or state-derived signal with no combinational path from out_ready.
REQ-019 out_valid = 1 iff buffer[rsel] is FULL; out_data is the buffer[rsel] register contents, and rsel toggles on each output handshake.
REQ-020 Latency: a block's 16th byte is accepted in cycle N; out_valid is asserted in cycle N+1 when that buffer is buffer[rsel].
REQ-021 Sustained throughput is 1 byte/cycle with out_ready=1; there are no bubbles between blocks.
REQ-022 Simultaneous events: an input handshake on the 16th byte into one buffer and an output handshake on the other buffer in the same cycle are both honoured.
REQ-023 out_data and out_valid shall remain stable while out_valid=1 and out_ready=0.
REQ-024 clr=1 returns both buffers to EMPTY, clears the counter, wsel and rsel, and forces out_valid=0 on the next cycle; clr overrides any coincident handshake; buffer data need not be cleared.
REQ-025 Accepting a byte when buffer[wsel] is EMPTY overwrites stale data; no partial block is ever presented.

Reset
REQ-026 When rst=0, asynchronously set buffers to 0, counter to 0, wsel and rsel to 0, all buffer states to EMPTY, out_valid=0, out_data=0, in_ready=1.
REQ-027 Reset asserted mid-block discards the partial block; after rst is released, the first accepted byte is source byte 0.

Structure
REQ-028 A shared aes_pkg holds BLOCK_BYTES=16, the buffer-state enum (EMPTY, FILLING, FULL), and the function inv_sr_dest(idx) returning the destination index.
REQ-029 The inverse row-rotation index function in aes_pkg is shared with the forward ShiftRows block.
REQ-030 One sub-module, isr_block_buf (a single 128-bit buffer with state), is instantiated twice.

Verification
REQ-031 Bytes 0x00..0x0F, out_ready=1 -> out_valid one cycle after the 16th byte, out_data=0x0C0F0E0D_09080B0A_06050407_03020100.
REQ-032 Round-trip: forward ShiftRows of 0x0C0F0E0D_09080B0A_06050407_03020100 (byte 15 is the MSB) -> 0x0F0E0D0C_0B0A0908_07060504_03020100.
REQ-033 out_ready=0, 48 bytes offered -> in_ready falls after byte 32, out_data holds block 1 stable; raising out_ready drains blocks 1 and 2 in order, then block 3 is accepted.
REQ-034 Continuous 64 bytes, out_ready=1 -> 4 blocks out, no in_ready deassertion, out_valid pulses 16 cycles apart.
REQ-035 clr after byte 7 of a block, then bytes 0x10..0x1F -> only one block out, equal to REQ-031's result plus 0x10 per byte.
REQ-036 rst pulse while one buffer is FULL and the other is FILLING -> all outputs at reset values; the next 16 bytes form a correct block.

Source files
------------

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the streaming ShiftRows / InvShiftRows blocks.
//   BLOCK_BYTES  : bytes per AES state block (16)
//   BLOCK_BITS   : bits per AES state block (128)
//   buf_state_e  : life cycle of one block buffer (EMPTY, FILLING, FULL)
//   inv_sr_dest  : destination slot of a source byte under InvShiftRows
//   sr_dest      : destination slot of a source byte under ShiftRows
// Byte index j = 4r + c, where r = j/4 is the row and c = j%4 is the column.
// ----------------------------------------------------------------------------
package aes_pkg;

   localparam int BLOCK_BYTES = 16;
   localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } buf_state_e;

   // InvShiftRows rotates row r right by r, so the source byte in column c
   // lands in column (c + r) mod 4 of the same row.
   function automatic logic [3:0] inv_sr_dest(input logic [3:0] idx);
      logic [1:0] row;
      logic [1:0] col;
      row = idx[3:2];
      col = idx[1:0];
      return {row, 2'(col + row)};
   endfunction

   // ShiftRows rotates row r left by r: column c goes to (c - r) mod 4.
   function automatic logic [3:0] sr_dest(input logic [3:0] idx);
      logic [1:0] row;
      logic [1:0] col;
      row = idx[3:2];
      col = idx[1:0];
      return {row, 2'(col - row)};
   endfunction

endpackage

// File: rtl/isr_block_buf.sv
// ----------------------------------------------------------------------------
// isr_block_buf
// One 128-bit block buffer with its EMPTY/FILLING/FULL state. Each written
// byte is placed straight into its InvShiftRows destination slot, so a FULL
// buffer already holds the transformed block.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (data and state cleared)
//   clr     : synchronous flush to EMPTY; overrides wr_en / rd_en
//   wr_en   : write wr_byte as source byte wr_idx of the block
//   wr_last : this write is the 16th byte of the block
//   wr_idx  : source byte index 0..15
//   wr_byte : byte value
//   rd_en   : the consumer takes the block this cycle (buffer must be FULL)
//   state   : current buffer state
//   data    : buffer contents, byte j at bits [8j+7:8j]
// ----------------------------------------------------------------------------
module isr_block_buf
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic                  wr_last,
   input  logic [3:0]            wr_idx,
   input  logic [7:0]            wr_byte,
   input  logic                  rd_en,
   output buf_state_e            state,
   output logic [BLOCK_BITS-1:0] data
);

   buf_state_e state_d;
   logic [3:0] slot;

   assign slot = inv_sr_dest(wr_idx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= state_d;
   end

   // A write and a read never target the same buffer in one cycle: writes
   // need a non-FULL buffer, reads need a FULL one.
   always_comb begin
      state_d = state;
      if (clr) begin
         state_d = EMPTY;
      end else if (rd_en) begin
         state_d = EMPTY;
      end else if (wr_en) begin
         state_d = wr_last ? FULL : FILLING;
      end
   end

   // Stale contents are not cleared on flush or drain: all 16 slots are
   // rewritten before the buffer can become FULL again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
      end else if (wr_en && !clr) begin
         data[{slot, 3'b000} +: 8] <= wr_byte;
      end
   end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// ----------------------------------------------------------------------------
// inv_shift_rows_stream
// Byte-serial to block-parallel AES InvShiftRows with a two-block ping-pong
// buffer. Bytes arrive one per handshake in source order 0..15; complete
// transformed blocks are presented 128 bits wide.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   clr       : synchronous flush of all partial and full blocks
//   in_valid  : in_data carries a state byte
//   in_ready  : a byte is accepted this cycle (state-derived only)
//   in_data   : state byte
//   out_valid : out_data holds a complete transformed block
//   out_ready : consumer takes out_data this cycle
//   out_data  : transformed block, byte j at bits [8j+7:8j]
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid is held with stable data until ready, and ready never
// depends combinationally on the opposite side.
// ----------------------------------------------------------------------------
module inv_shift_rows_stream
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BLOCK_BITS-1:0] out_data
);

   logic [3:0]            cnt;
   logic                  wsel;
   logic                  rsel;
   logic                  in_hs;
   logic                  out_hs;
   logic                  wr_last;
   buf_state_e            st0;
   buf_state_e            st1;
   logic [BLOCK_BITS-1:0] data0;
   logic [BLOCK_BITS-1:0] data1;
   buf_state_e            wr_state;
   buf_state_e            rd_state;

   assign wr_state  = wsel ? st1 : st0;
   assign rd_state  = rsel ? st1 : st0;

   // Both flags come straight from buffer state registers, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = (wr_state != FULL);
   assign out_valid = (rd_state == FULL);
   assign out_data  = rsel ? data1 : data0;

   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign wr_last   = (cnt == 4'(BLOCK_BYTES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         wsel <= 1'b0;
         rsel <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         wsel <= 1'b0;
         rsel <= 1'b0;
      end else begin
         if (in_hs) begin
            cnt <= cnt + 4'd1;
            if (wr_last) wsel <= ~wsel;
         end
         if (out_hs) rsel <= ~rsel;
      end
   end

   isr_block_buf u_buf0 (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .wr_en   (in_hs && !wsel),
      .wr_last (wr_last),
      .wr_idx  (cnt),
      .wr_byte (in_data),
      .rd_en   (out_hs && !rsel),
      .state   (st0),
      .data    (data0)
   );

   isr_block_buf u_buf1 (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .wr_en   (in_hs && wsel),
      .wr_last (wr_last),
      .wr_idx  (cnt),
      .wr_byte (in_data),
      .rd_en   (out_hs && rsel),
      .state   (st1),
      .data    (data1)
   );

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// ----------------------------------------------------------------------------
// tb_inv_shift_rows_stream
// Self-checking bench for inv_shift_rows_stream. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_inv_shift_rows_stream;

   logic         clk;
   logic         rst;
   logic         clr;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   inv_shift_rows_stream dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   logic [7:0]   byte_q[$];
   logic [127:0] exp_q[$];
   int           out_cyc[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_out = 0;
   int           cyc = 0;
   int           stalls = 0;
   logic [127:0] last_out;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: out[4r+c] = in[4r + ((c - r) mod 4)].
   function automatic logic [127:0] inv_sr_model(input logic [7:0] src[16]);
      logic [127:0] res;
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            res[8*(4*r+c) +: 8] = src[4*r + ((c - r + 4) % 4)];
      return res;
   endfunction

   // Forward ShiftRows: out[4r+c] = in[4r + ((c + r) mod 4)].
   function automatic logic [127:0] sr_model(input logic [127:0] blk);
      logic [127:0] res;
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            res[8*(4*r+c) +: 8] = blk[8*(4*r + ((c + r) % 4)) +: 8];
      return res;
   endfunction

   // One clock cycle: check the present outputs, drive inputs, update model.
   // A block is pending in the model as soon as its 16th byte is accepted,
   // so out_valid must be high from the next sample on. With two buffers
   // the writer stalls exactly when two complete blocks are waiting.
   task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, output logic acc);
      logic [7:0] src[16];
      logic       ohs;
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      if (out_valid && exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      acc = iv && in_ready;
      ohs = out_valid && ordy;
      if (iv && !in_ready) stalls++;
      if (ohs) begin
         n_out++;
         last_out = out_data;
         out_cyc.push_back(cyc);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (acc) begin
         byte_q.push_back(d);
         if (byte_q.size() == 16) begin
            for (int i = 0; i < 16; i++) src[i] = byte_q[i];
            exp_q.push_back(inv_sr_model(src));
            byte_q.delete();
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   // driver: offer bytes until n are accepted or the budget runs out
   task automatic feed(input int n, input logic ordy, input logic rnd, input logic [7:0] base,
                       input int budget);
      int k;
      int t;
      logic [7:0] d;
      logic acc;
      k = 0;
      t = 0;
      while (k < n && t < budget) begin
         d = rnd ? 8'($urandom) : base + 8'(k);
         cycle(1'b1, d, ordy, acc);
         if (acc) k++;
         t++;
      end
      chk("feed_accepted", k, n);
   endtask

   task automatic drain(input int budget);
      int t;
      logic acc;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         cycle(1'b0, 8'h00, 1'b1, acc);
         t++;
      end
      chk("drain_empty", exp_q.size(), 0);
      cycle(1'b0, 8'h00, 1'b1, acc);
   endtask

   task automatic do_clr();
      clr       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      out_ready = 1'b1;
      @(negedge clk);
      cyc++;
      clr      = 1'b0;
      in_valid = 1'b0;
      byte_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int   base_out;
      int   acc_cnt;
      logic acc;

      rst = 1'b0;
      clr = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_data", out_data, 128'h0);
      rst = 1'b1;

      // counting pattern 0x00..0x0F
      base_out = n_out;
      feed(16, 1'b1, 1'b0, 8'h00, 20);
      drain(10);
      chk("count_blocks", n_out - base_out, 1);
      chk("count_block", last_out, 128'h0C0F0E0D_09080B0A_06050407_03020100);
      chk("round_trip", sr_model(last_out), 128'h0F0E0D0C_0B0A0908_07060504_03020100);

      // back-pressure: 48 bytes offered with out_ready low
      acc_cnt = 0;
      base_out = n_out;
      for (int i = 0; i < 48; i++) begin
         cycle(1'b1, 8'($urandom), 1'b0, acc);
         if (acc) acc_cnt++;
      end
      chk("stall_accepted", acc_cnt, 32);
      chk("stall_pending", exp_q.size(), 2);
      feed(16, 1'b1, 1'b1, 8'h00, 100);
      drain(40);
      chk("stall_blocks", n_out - base_out, 3);

      // continuous 64 bytes with out_ready high
      stalls = 0;
      out_cyc.delete();
      feed(64, 1'b1, 1'b1, 8'h00, 70);
      drain(10);
      chk("stream_stalls", stalls, 0);
      chk("stream_blocks", out_cyc.size(), 4);
      for (int i = 1; i < out_cyc.size(); i++)
         chk("stream_spacing", out_cyc[i] - out_cyc[i-1], 16);

      // randomized valid/ready traffic
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, acc);
      drain(60);

      // flush mid-block
      feed(8, 1'b1, 1'b0, 8'h00, 10);
      do_clr();
      base_out = n_out;
      feed(16, 1'b1, 1'b0, 8'h10, 20);
      drain(10);
      chk("clr_blocks", n_out - base_out, 1);
      chk("clr_block", last_out, 128'h1C1F1E1D_19181B1A_16151417_13121110);

      // asynchronous reset with one buffer FULL and the other FILLING
      feed(24, 1'b0, 1'b1, 8'h00, 30);
      chk("pre_rst_pending", exp_q.size(), 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_data", out_data, 128'h0);
      byte_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      base_out = n_out;
      feed(16, 1'b1, 1'b0, 8'h40, 20);
      drain(10);
      chk("post_rst_blocks", n_out - base_out, 1);
      chk("post_rst_block", last_out, 128'h4C4F4E4D_49484B4A_46454447_43424140);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
